dm_cache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the processor load/store port and slow_memory.
- Processor side: single-word (32-bit) read/write with a stall output.
- Memory side: 128-bit block transfers on the slow_memory handshake (mem_read/mem_write held until the one-cycle mem_ready pulse).
- Hits complete in zero stall cycles. Misses stall until the line is filled, plus a dirty writeback first when the victim is dirty.

---
 rtl/cache_pkg.sv | 62 ++++++
 rtl/cache_line_array.sv | 53 +++++
 rtl/dm_cache_wb.sv | 122 ++++++++++++
 tb/tb_dm_cache_wb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped
// write-back data cache.
package cache_pkg;

    localparam int NUM_BLOCKS = 8;
    localparam int INDEX_W    = 3;
    localparam int TAG_W      = 28 - INDEX_W;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 30;
    localparam int BADDR_W    = 28;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    function automatic logic [1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[1:0];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[INDEX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:INDEX_W+2];
    endfunction

    function automatic logic [BADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2];
    endfunction

    // Word 0 lives in the least significant 32 bits of a line.
    function automatic logic [WORD_W-1:0] line_word(input logic [BLOCK_W-1:0] line,
                                                    input logic [1:0] sel);
        logic [WORD_W-1:0] w;
        case (sel)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

    function automatic logic [BLOCK_W-1:0] line_set_word(input logic [BLOCK_W-1:0] line,
                                                         input logic [1:0] sel,
                                                         input logic [WORD_W-1:0] w);
        logic [BLOCK_W-1:0] r;
        r = line;
        case (sel)
            2'd0:    r[31:0]   = w;
            2'd1:    r[63:32]  = w;
            2'd2:    r[95:64]  = w;
            default: r[127:96] = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty/tag/data per line, one combinational read port and
// one write port that either replaces a whole line or updates a single word.
module cache_line_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_line,
    input  logic               word_we,
    input  logic [1:0]         word_sel,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               fill_we,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_line
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    // Only the status bits are cleared; stale tag/data are masked by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (word_we) begin
            data_q[idx] <= line_set_word(data_q[idx], word_sel, word_data);
        end
    end

endmodule

// File: rtl/dm_cache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between a single-word
// processor port and a 128-bit block memory with a mem_ready pulse handshake.
module dm_cache_wb
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [WORD_W-1:0]   proc_wdata,
    output logic [WORD_W-1:0]   proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [BADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0]  mem_wdata,
    input  logic [BLOCK_W-1:0]  mem_rdata,
    input  logic                mem_ready
);

    cache_state_t state_q;
    cache_state_t state_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         word_sel;
    logic               req;
    logic               hit;

    logic               rd_valid;
    logic               rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_line;
    logic               word_we;
    logic               fill_we;

    assign idx      = addr_index(proc_addr);
    assign req_tag  = addr_tag(proc_addr);
    assign word_sel = addr_word(proc_addr);
    assign req      = proc_read | proc_write;
    assign hit      = rd_valid && (rd_tag == req_tag);

    cache_line_array u_lines (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .word_data (proc_wdata),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_line (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst so a reset in the middle of a memory transfer
    // drops the request at once rather than at the next edge.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        word_we    = 1'b0;
        fill_we    = 1'b0;
        if (!rst) begin
            case (state_q)
                COMPARE: begin
                    if (req) begin
                        if (hit) begin
                            // Read and write together resolves to a write.
                            if (proc_write) begin
                                word_we = 1'b1;
                            end else begin
                                proc_rdata = line_word(rd_line, word_sel);
                            end
                        end else begin
                            proc_stall = 1'b1;
                            state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    proc_stall = 1'b1;
                    mem_write  = 1'b1;
                    mem_addr   = {rd_tag, idx};
                    mem_wdata  = rd_line;
                    if (mem_ready) begin
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    proc_stall = 1'b1;
                    mem_read   = 1'b1;
                    mem_addr   = addr_block(proc_addr);
                    if (mem_ready) begin
                        fill_we = 1'b1;
                        state_d = COMPARE;
                    end
                end
                default: begin
                    state_d = COMPARE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_wb.sv
// Bench for dm_cache_wb: behavioural slow memory, word-level reference memory,
// hand sequences for the multi-cycle corners and a table of access vectors.
module tb_dm_cache_wb;

    logic         clk;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    logic         mdl_ready;
    logic [127:0] mdl_rdata;
    logic         inj_ready;
    logic [127:0] inj_rdata;

    assign mem_ready = mdl_ready | inj_ready;
    assign mem_rdata = inj_ready ? inj_rdata : mdl_rdata;

    dm_cache_wb dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_txn_t;
    mem_txn_t log_q[$];

    logic [127:0] mem_blk [logic [27:0]];
    logic [31:0]  ref_mem [logic [29:0]];
    int           mem_lat  = 0;
    int           both_cnt = 0;

    function automatic logic [31:0] blk_word(input logic [27:0] b, input logic [1:0] k);
        return {2'b10, k, b};
    endfunction

    function automatic logic [127:0] blk_init(input logic [27:0] b);
        return {blk_word(b, 2'd3), blk_word(b, 2'd2), blk_word(b, 2'd1), blk_word(b, 2'd0)};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return blk_word(a[29:2], a[1:0]);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- slow memory model ----------------
    // Reacts 2 time units after each rising edge so mem_ready is stable well
    // before the edge on which the cache samples it.
    int cnt     = 0;
    int cur_lat = 1;
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mdl_ready = 1'b0;
            cnt       = 0;
        end else if (mdl_ready) begin
            mdl_ready = 1'b0;
        end else if (mem_read || mem_write) begin
            if (mem_read && mem_write) both_cnt++;
            if (cnt == 0) begin
                log_q.push_back('{wr: mem_write, addr: mem_addr, data: mem_wdata});
                cur_lat = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
            end
            cnt++;
            if (cnt >= cur_lat) begin
                if (mem_write) mem_blk[mem_addr] = mem_wdata;
                else mdl_rdata = mem_blk.exists(mem_addr) ? mem_blk[mem_addr] : blk_init(mem_addr);
                mdl_ready = 1'b1;
                cnt       = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] d, output int stalls, output int ops);
        int  n0;
        bit  done;
        logic [31:0] e;
        n0     = log_q.size();
        stalls = 0;
        done   = 0;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
        if (rd && !wr) exp_q.push_back(ref_rd(a));
        if (wr) ref_mem[a] = d;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (proc_stall) stalls++;
            else done = 1;
        end
        if (!done) begin
            chk("access_timeout", 0, 1);
            if (rd && !wr) void'(exp_q.pop_front());
        end else if (rd && !wr) begin
            e = exp_q.pop_front();
            chk($sformatf("rdata@%h", a), proc_rdata, e);
        end
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        ops = log_q.size() - n0;
    endtask

    task automatic wait_neg(input int which, output bit ok);
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            case (which)
                0:       ok = mem_read;
                1:       ok = mem_ready;
                default: ok = !proc_stall;
            endcase
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          exp_ops;
    } vec_t;
    vec_t vecs[17];

    initial begin
        int  stalls;
        int  ops;
        int  n;
        bit  ok;

        vecs[0]  = '{1, 0, 30'h000,      32'h0, 1};
        vecs[1]  = '{1, 0, 30'h003,      32'h0, 0};
        vecs[2]  = '{0, 1, 30'h002,      $urandom, 0};
        vecs[3]  = '{1, 0, 30'h002,      32'h0, 0};
        vecs[4]  = '{1, 0, 30'h020,      32'h0, 2};
        vecs[5]  = '{1, 0, 30'h002,      32'h0, 1};
        vecs[6]  = '{0, 1, 30'h01C,      $urandom, 1};
        vecs[7]  = '{0, 1, 30'h01D,      $urandom, 0};
        vecs[8]  = '{1, 0, 30'h03C,      32'h0, 2};
        vecs[9]  = '{1, 0, 30'h01D,      32'h0, 1};
        vecs[10] = '{1, 1, 30'h01E,      $urandom, 0};
        vecs[11] = '{1, 0, 30'h01E,      32'h0, 0};
        vecs[12] = '{0, 1, 30'h3FFFFFFF, $urandom, 2};
        vecs[13] = '{1, 0, 30'h3FFFFFFC, 32'h0, 0};
        vecs[14] = '{1, 0, 30'h3FFFFFFF, 32'h0, 0};
        vecs[15] = '{1, 0, 30'h01C,      32'h0, 2};
        vecs[16] = '{1, 0, 30'h004,      32'h0, 1};

        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mdl_ready  = 1'b0;
        mdl_rdata  = '0;
        inj_ready  = 1'b0;
        inj_rdata  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_stall", proc_stall, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", proc_rdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold read miss on 0x10
        mem_lat   = 2;
        proc_read = 1'b1;
        proc_addr = 30'h10;
        @(negedge clk);
        chk("cold_stall", proc_stall, 1);
        wait_neg(0, ok);
        chk("cold_req_seen", ok, 1);
        chk("cold_mem_addr", mem_addr, 28'h4);
        chk("cold_no_write", mem_write, 0);
        wait_neg(1, ok);
        chk("cold_ready_seen", ok, 1);
        @(negedge clk);
        chk("cold_stall_after_fill", proc_stall, 0);
        chk("cold_rdata", proc_rdata, blk_word(28'h4, 2'd0));
        @(posedge clk);
        #1;
        proc_read = 1'b0;
        mem_lat   = 0;

        // Write hit then read hit on 0x11
        access(0, 1, 30'h11, 32'hDEADBEEF, stalls, ops);
        chk("wr_hit_stalls", stalls, 0);
        chk("wr_hit_ops", ops, 0);
        access(1, 0, 30'h11, 32'h0, stalls, ops);
        chk("rd_hit_stalls", stalls, 0);
        chk("rd_hit_ops", ops, 0);

        // Dirty conflict miss: writeback of block 4 then fill of block 0xC
        access(1, 0, 30'h30, 32'h0, stalls, ops);
        chk("dirty_miss_ops", ops, 2);
        n = log_q.size();
        chk("wb_is_write", log_q[n-2].wr, 1);
        chk("wb_addr", log_q[n-2].addr, 28'h4);
        chk("wb_word1", log_q[n-2].data[63:32], 32'hDEADBEEF);
        chk("wb_word0", log_q[n-2].data[31:0], blk_word(28'h4, 2'd0));
        chk("alloc_is_read", log_q[n-1].wr, 0);
        chk("alloc_addr", log_q[n-1].addr, 28'hC);

        // Write miss on a clean line: one fill, then the word is dirty
        access(0, 1, 30'h44, 32'hCAFE0001, stalls, ops);
        chk("wmiss_ops", ops, 1);
        chk("wmiss_fill_only", log_q[log_q.size()-1].wr, 0);
        chk("wmiss_fill_addr", log_q[log_q.size()-1].addr, 28'h11);
        access(1, 0, 30'h64, 32'h0, stalls, ops);
        chk("wmiss_evict_ops", ops, 2);
        n = log_q.size();
        chk("wmiss_wb_write", log_q[n-2].wr, 1);
        chk("wmiss_wb_addr", log_q[n-2].addr, 28'h11);
        chk("wmiss_wb_word0", log_q[n-2].data[31:0], 32'hCAFE0001);

        // Stray mem_ready while idle must not disturb anything
        inj_rdata = {4{32'hFFFF_FFFF}};
        inj_ready = 1'b1;
        @(negedge clk);
        chk("idle_rdy_stall", proc_stall, 0);
        chk("idle_rdy_mem_read", mem_read, 0);
        chk("idle_rdy_mem_write", mem_write, 0);
        @(posedge clk);
        #1;
        inj_ready = 1'b0;
        access(1, 0, 30'h31, 32'h0, stalls, ops);
        chk("idle_rdy_hit_ops", ops, 0);
        chk("idle_rdy_hit_stalls", stalls, 0);

        // Reset while a fill is outstanding
        mem_lat   = 50;
        proc_read = 1'b1;
        proc_addr = 30'h80;
        wait_neg(0, ok);
        chk("rst_alloc_seen", ok, 1);
        chk("rst_alloc_addr", mem_addr, 28'h20);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_mem_read", mem_read, 0);
        chk("rst_async_stall", proc_stall, 0);
        chk("rst_async_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst     = 1'b0;
        mem_lat = 0;
        @(negedge clk);
        chk("rst_reread_stall", proc_stall, 1);
        chk("rst_reread_mem_read", mem_read, 1);
        chk("rst_reread_addr", mem_addr, 28'h20);
        wait_neg(2, ok);
        chk("rst_reread_done", ok, 1);
        chk("rst_reread_rdata", proc_rdata, blk_word(28'h20, 2'd0));
        @(posedge clk);
        #1;
        proc_read = 1'b0;
        access(1, 0, 30'h30, 32'h0, stalls, ops);
        chk("rst_invalidated_ops", ops, 1);

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls, ops);
            chk($sformatf("vec%0d_ops", i), ops, vecs[i].exp_ops);
            if (vecs[i].exp_ops == 0) chk($sformatf("vec%0d_stalls", i), stalls, 0);
        end

        // Random traffic over a few conflicting tags, checked against the reference
        for (int i = 0; i < 60; i++) begin
            logic [29:0] a;
            bit          w;
            a = 30'($urandom_range(0, 255));
            w = ($urandom_range(0, 1) == 1);
            access(!w, w, a, $urandom, stalls, ops);
        end

        chk("mem_rw_exclusive", both_cnt, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
